lpc_host: RTL and testbench
===========================

# lpc_host

LPC host-side cycle generator: the initiator for the LPC peripheral target on the same bus. It takes single I/O read/write requests from a local valid/ready interface and drives LFRAME# and LAD[3:0] through START, CYCTYPE, ADDR, DATA and TAR. It then samples the target's SYNC and read data and returns data plus status. It also handles SYNC waits, error SYNC, and timeout with an LPC abort. It sits between the platform test/bridge logic and the LPC pins, and is the stimulus source for target-side bring-up.

## Interface
- SYNC_TIMEOUT, 8: consecutive SYNC-phase cycles with no recognised SYNC nibble before abort.
- WAIT_MAX, 64: total short/long-wait SYNC cycles tolerated before abort.
- clk_i  in  1  LPC clock; all logic on rising edge.
- nrst_i  in  1  reset, asynchronous, active-low.
- lframe_o  out  1  LFRAME#, active low.
- lad_bus  inout  4  LAD; driven only in host-drive phases, else 4'bzzzz.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  high only in IDLE; transfer on valid&&ready.
- req_write_i  in  1  1 = I/O write, 0 = I/O read.
- req_addr_i  in  16  I/O address.
- req_wdata_i  in  8  write data.
- resp_valid_o  out  1  one-cycle pulse at cycle end.
- resp_rdata_o  out  8  read data; valid with resp_valid_o, held until next response.
- resp_status_o  out  2  00 OK, 01 target error SYNC (1010), 10 timeout/abort.
- busy_o  out  1  high from acceptance until resp_valid_o.

## Operation
- Request fields are latched on acceptance. The request is not re-sampled afterwards.
- States: IDLE, START, CYCTYPE, ADDR(4), WDATA(2, write only), TAR(2), SYNC, RDATA(2, read only), FTAR(2), ABORT(4), RESP.
- IDLE: lframe_o=1, LAD floated, req_ready_o=1.
- START: lframe_o=0, LAD=0000.
- CYCTYPE: lframe_o=1, LAD=0000 for read, 0010 for write.
- ADDR: addr[15:12], [11:8], [7:4], [3:0], one nibble per cycle.
- WDATA: wdata[3:0], then wdata[7:4].
- TAR: cycle 1 drives 1111; cycle 2 floats LAD.
- SYNC: LAD floated and sampled each cycle.
  - 0000: ready; go to RDATA (read) or FTAR (write).
  - 1010: error; same path, status 01; read data is still captured.
  - 0101 or 0110: wait; stay in SYNC and increment the wait counter. A total above WAIT_MAX goes to ABORT.
  - Any other nibble: increment the timeout counter. Reaching SYNC_TIMEOUT goes to ABORT. A valid SYNC nibble clears this counter.
- RDATA: sample rdata[3:0], then rdata[7:4].
- FTAR: 2 cycles with LAD floated; the target drives 1111.
- ABORT: lframe_o=0 and LAD=1111 for 4 cycles, then RESP with status 10. rdata is unchanged.
- RESP: resp_valid_o=1 for one cycle, then IDLE.
- Counters are cleared on acceptance and saturate; they never wrap.
- A request asserted while busy is held off (req_ready_o=0) and accepted in the first IDLE cycle.

## Timing
- Reset values: lframe_o=1, LAD=z, req_ready_o=1, resp_valid_o=0, resp_rdata_o=8'h00, resp_status_o=2'b00, busy_o=0, state IDLE.
- Reset is asynchronous and may assert mid-cycle. LFRAME# releases and LAD floats immediately, with no response pulse. Operation restarts from IDLE on the first edge after deassertion.
- Acceptance at edge T: START occupies cycle T+1.
- Zero-wait write: START, CYCTYPE, 4 ADDR, 2 WDATA, 2 TAR, 1 SYNC, 2 FTAR = 13 cycles. resp_valid_o is at T+14.
- Zero-wait read: START, CYCTYPE, 4 ADDR, 2 TAR, 1 SYNC, 2 RDATA, 2 FTAR = 13 cycles, also T+14.
- Each wait cycle adds 1 cycle.
- Minimum request-to-request spacing: 15 cycles, with 1 IDLE cycle between frames.
- LAD output enable changes only on clock edges. It is never asserted in TAR2, SYNC, RDATA or FTAR.

## Structure
- Extend the shared lpc_defines.v with:
  - host state encodings (`LPC_HST_*`);
  - SYNC codes: READY 0000, SHORT_WAIT 0101, LONG_WAIT 0110, ERROR 1010;
  - CYCTYPE nibbles: IO_RD 0000, IO_WR 0010;
  - the status codes.
- One sub-module is natural: lpc_host_sync_mon, holding the wait/timeout counters and SYNC nibble classification. It outputs ready, error and abort strobes.
- The FSM, nibble mux and shift registers stay in lpc_host.

## Test plan
- Write 0x0080, data 0xA5, BFM target returns SYNC 0000 -> LAD sequence 0,2,0,0,8,0,5,A,F,z; resp_valid at T+14, status 00.
- Read 0x002E, target gives 0101, 0101, then 0000, then data 0x5A -> rdata 0x5A, status 00, resp at T+16.
- Read with no target (LAD pulled to 1111) -> after 8 SYNC cycles, LFRAME low 4 cycles with LAD=1111; status 10; rdata unchanged.
- Write with target SYNC 1010 -> full FTAR completes, status 01, response at T+14.
- req_valid held during a cycle -> req_ready_o=0 until IDLE; second frame's START exactly 1 cycle after first resp_valid_o.
- nrst_i asserted during ADDR nibble 2 -> lframe_o=1 and LAD z asynchronously; no resp_valid_o; a new request after release completes normally.

Source files
------------

// File: rtl/lpc_host_pkg.sv
// Shared definitions for the LPC host cycle generator: FSM states, SYNC and CYCTYPE
// nibbles, response status codes and the address nibble selector.
package lpc_host_pkg;

  localparam logic [3:0] SyncReady     = 4'b0000;
  localparam logic [3:0] SyncShortWait = 4'b0101;
  localparam logic [3:0] SyncLongWait  = 4'b0110;
  localparam logic [3:0] SyncError     = 4'b1010;

  localparam logic [3:0] CyctypeIoRd = 4'b0000;
  localparam logic [3:0] CyctypeIoWr = 4'b0010;

  // Nibble driven in TAR1 and ABORT.
  localparam logic [3:0] LadAllOnes = 4'b1111;

  typedef enum logic [1:0] {
    StatusOk    = 2'b00,
    StatusErr   = 2'b01,
    StatusAbort = 2'b10
  } lpc_status_e;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StCyctype,
    StAddr,
    StWdata,
    StTar,
    StSync,
    StRdata,
    StFtar,
    StAbort,
    StResp
  } lpc_hst_state_e;

  // Address goes out most significant nibble first.
  function automatic logic [3:0] addr_nibble(input logic [15:0] addr, input logic [1:0] idx);
    logic [3:0] nib;
    case (idx)
      2'd0:    nib = addr[15:12];
      2'd1:    nib = addr[11:8];
      2'd2:    nib = addr[7:4];
      default: nib = addr[3:0];
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/lpc_host_sync_mon.sv
// SYNC-phase monitor: classifies the sampled LAD nibble and keeps the saturating
// wait and timeout counters that decide when the host gives up and aborts.
module lpc_host_sync_mon
  import lpc_host_pkg::*;
#(
  parameter int unsigned SYNC_TIMEOUT = 8,
  parameter int unsigned WAIT_MAX     = 64
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic       clear_i,
  input  logic       sample_i,
  input  logic [3:0] nibble_i,
  output logic       ready_o,
  output logic       error_o,
  output logic       abort_o
);

  localparam int unsigned ToW   = $clog2(SYNC_TIMEOUT + 1);
  localparam int unsigned WaitW = $clog2(WAIT_MAX + 2);

  localparam logic [ToW-1:0]   ToLast    = ToW'(SYNC_TIMEOUT - 1);
  localparam logic [ToW-1:0]   ToSat     = ToW'(SYNC_TIMEOUT);
  localparam logic [WaitW-1:0] WaitLimit = WaitW'(WAIT_MAX);
  localparam logic [WaitW-1:0] WaitSat   = WaitW'(WAIT_MAX + 1);

  logic [ToW-1:0]   to_cnt_q, to_cnt_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             is_ready, is_err, is_wait, is_valid;

  always_comb begin
    is_ready = (nibble_i == SyncReady);
    is_err   = (nibble_i == SyncError);
    is_wait  = (nibble_i == SyncShortWait) || (nibble_i == SyncLongWait);
    is_valid = is_ready || is_err || is_wait;

    ready_o = sample_i && is_ready;
    error_o = sample_i && is_err;
    // Abort on the cycle that would push either counter past its limit.
    abort_o = sample_i && ((is_wait && (wait_cnt_q >= WaitLimit)) ||
                           (!is_valid && (to_cnt_q >= ToLast)));

    to_cnt_d   = to_cnt_q;
    wait_cnt_d = wait_cnt_q;
    if (clear_i) begin
      to_cnt_d   = '0;
      wait_cnt_d = '0;
    end else if (sample_i) begin
      if (is_valid) begin
        to_cnt_d = '0;
      end else if (to_cnt_q < ToSat) begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
      if (is_wait && (wait_cnt_q < WaitSat)) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      to_cnt_q   <= '0;
      wait_cnt_q <= '0;
    end else begin
      to_cnt_q   <= to_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/lpc_host.sv
// LPC host cycle generator: turns single I/O read/write requests into LPC frames
// on LFRAME#/LAD and returns the target's read data and completion status.
module lpc_host
  import lpc_host_pkg::*;
#(
  parameter int unsigned SYNC_TIMEOUT = 8,
  parameter int unsigned WAIT_MAX     = 64
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  output logic        lframe_o,
  inout  wire  [3:0]  lad_bus,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [15:0] req_addr_i,
  input  logic [7:0]  req_wdata_i,
  output logic        resp_valid_o,
  output logic [7:0]  resp_rdata_o,
  output logic [1:0]  resp_status_o,
  output logic        busy_o
);

  lpc_hst_state_e state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic           write_q, write_d;
  logic [15:0]    addr_q, addr_d;
  logic [7:0]     wdata_q, wdata_d;
  logic [7:0]     rdata_sh_q, rdata_sh_d;
  lpc_status_e    status_q, status_d;
  logic [7:0]     resp_rdata_q, resp_rdata_d;
  lpc_status_e    resp_status_q, resp_status_d;

  logic       lad_oe;
  logic [3:0] lad_out;
  logic [3:0] lad_in;
  logic       lframe;
  logic       mon_clear, mon_sample, mon_ready, mon_error, mon_abort;

  assign lad_in  = lad_bus;
  assign lad_bus = lad_oe ? lad_out : 4'bzzzz;

  lpc_host_sync_mon #(
    .SYNC_TIMEOUT(SYNC_TIMEOUT),
    .WAIT_MAX    (WAIT_MAX)
  ) u_sync_mon (
    .clk_i   (clk_i),
    .nrst_i  (nrst_i),
    .clear_i (mon_clear),
    .sample_i(mon_sample),
    .nibble_i(lad_in),
    .ready_o (mon_ready),
    .error_o (mon_error),
    .abort_o (mon_abort)
  );

  assign mon_sample = (state_q == StSync);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_sh_d    = rdata_sh_q;
    status_d      = status_q;
    resp_rdata_d  = resp_rdata_q;
    resp_status_d = resp_status_q;
    lad_oe        = 1'b0;
    lad_out       = 4'b0000;
    lframe        = 1'b1;
    mon_clear     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          write_d   = req_write_i;
          addr_d    = req_addr_i;
          wdata_d   = req_wdata_i;
          status_d  = StatusOk;
          cnt_d     = 2'd0;
          mon_clear = 1'b1;
          state_d   = StStart;
        end
      end
      StStart: begin
        lframe  = 1'b0;
        lad_oe  = 1'b1;
        lad_out = 4'b0000;
        state_d = StCyctype;
      end
      StCyctype: begin
        lad_oe  = 1'b1;
        lad_out = write_q ? CyctypeIoWr : CyctypeIoRd;
        cnt_d   = 2'd0;
        state_d = StAddr;
      end
      StAddr: begin
        lad_oe  = 1'b1;
        lad_out = addr_nibble(addr_q, cnt_q);
        cnt_d   = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          cnt_d   = 2'd0;
          state_d = write_q ? StWdata : StTar;
        end
      end
      StWdata: begin
        lad_oe  = 1'b1;
        lad_out = cnt_q[0] ? wdata_q[7:4] : wdata_q[3:0];
        cnt_d   = cnt_q[0] ? 2'd0 : 2'd1;
        if (cnt_q[0]) begin
          state_d = StTar;
        end
      end
      StTar: begin
        // Drive ones for one cycle, then hand the bus to the target.
        if (cnt_q == 2'd0) begin
          lad_oe  = 1'b1;
          lad_out = LadAllOnes;
          cnt_d   = 2'd1;
        end else begin
          cnt_d   = 2'd0;
          state_d = StSync;
        end
      end
      StSync: begin
        cnt_d = 2'd0;
        if (mon_abort) begin
          status_d = StatusAbort;
          state_d  = StAbort;
        end else if (mon_ready || mon_error) begin
          if (mon_error) begin
            status_d = StatusErr;
          end
          state_d = write_q ? StFtar : StRdata;
        end
      end
      StRdata: begin
        if (cnt_q == 2'd0) begin
          rdata_sh_d[3:0] = lad_in;
          cnt_d           = 2'd1;
        end else begin
          rdata_sh_d[7:4] = lad_in;
          cnt_d           = 2'd0;
          state_d         = StFtar;
        end
      end
      StFtar: begin
        if (cnt_q == 2'd0) begin
          cnt_d = 2'd1;
        end else begin
          cnt_d         = 2'd0;
          resp_status_d = status_q;
          if (!write_q) begin
            resp_rdata_d = rdata_sh_q;
          end
          state_d = StResp;
        end
      end
      StAbort: begin
        lframe  = 1'b0;
        lad_oe  = 1'b1;
        lad_out = LadAllOnes;
        cnt_d   = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          cnt_d         = 2'd0;
          resp_status_d = StatusAbort;
          state_d       = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q       <= StIdle;
      cnt_q         <= 2'd0;
      write_q       <= 1'b0;
      addr_q        <= 16'h0000;
      wdata_q       <= 8'h00;
      rdata_sh_q    <= 8'h00;
      status_q      <= StatusOk;
      resp_rdata_q  <= 8'h00;
      resp_status_q <= StatusOk;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_sh_q    <= rdata_sh_d;
      status_q      <= status_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_status_q <= resp_status_d;
    end
  end

  assign lframe_o      = lframe;
  assign req_ready_o   = (state_q == StIdle);
  assign busy_o        = (state_q != StIdle);
  assign resp_valid_o  = (state_q == StResp);
  assign resp_rdata_o  = resp_rdata_q;
  assign resp_status_o = resp_status_q;

endmodule

// File: tb/tb_lpc_host.sv
// Randomised bench for lpc_host: a frame-level model expands each request plus the
// target's SYNC script into the per-cycle bus trace, response timing and status.
module tb_lpc_host;

  localparam int unsigned SyncTimeout = 8;
  localparam int unsigned WaitMax     = 64;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        lframe_o;
  wire  [3:0]  lad_bus;
  logic        req_valid = 1'b0;
  logic        req_ready_o;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [7:0]  req_wdata = 8'h0;
  logic        resp_valid_o;
  logic [7:0]  resp_rdata_o;
  logic [1:0]  resp_status_o;
  logic        busy_o;

  logic       tgt_en = 1'b0;
  logic [3:0] tgt_val = 4'h0;
  assign lad_bus = tgt_en ? tgt_val : 4'bzzzz;

  always #5 clk = ~clk;

  lpc_host #(
    .SYNC_TIMEOUT(SyncTimeout),
    .WAIT_MAX    (WaitMax)
  ) dut (
    .clk_i        (clk),
    .nrst_i       (nrst),
    .lframe_o     (lframe_o),
    .lad_bus      (lad_bus),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .req_write_i  (req_write),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid_o),
    .resp_rdata_o (resp_rdata_o),
    .resp_status_o(resp_status_o),
    .busy_o       (busy_o)
  );

  int total = 0;
  int bad   = 0;

  // Expected frame, one entry per bus cycle starting with START and ending with RESP.
  logic       exp_lframe[$];
  logic       exp_oe[$];
  logic [3:0] exp_lad[$];
  logic       drv_en[$];
  logic [3:0] drv_val[$];
  logic [3:0] script[$];
  logic [1:0] exp_status;
  logic [7:0] mdl_rdata = 8'h00;

  logic [3:0] junk_tab[12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'h8,
                               4'h9, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

  task automatic push(input logic lf, input logic oe, input logic [3:0] lad,
                      input logic te, input logic [3:0] tv);
    exp_lframe.push_back(lf);
    exp_oe.push_back(oe);
    exp_lad.push_back(lad);
    drv_en.push_back(te);
    drv_val.push_back(tv);
  endtask

  // Expand one request into its frame; an exhausted script reads as the 1111 pull-up.
  task automatic build_frame(input logic wr, input logic [15:0] addr, input logic [7:0] wdata,
                             input logic [7:0] rdata);
    int         waits = 0;
    int         tmo = 0;
    bit         done = 0;
    bit         abort = 0;
    logic [3:0] n;
    exp_lframe.delete(); exp_oe.delete(); exp_lad.delete(); drv_en.delete(); drv_val.delete();
    exp_status = 2'b00;
    push(0, 1, 4'h0, 0, 4'h0);
    push(1, 1, wr ? 4'h2 : 4'h0, 0, 4'h0);
    for (int i = 0; i < 4; i++) push(1, 1, 4'(addr >> (12 - 4 * i)), 0, 4'h0);
    if (wr) begin
      push(1, 1, wdata[3:0], 0, 4'h0);
      push(1, 1, wdata[7:4], 0, 4'h0);
    end
    push(1, 1, 4'hF, 0, 4'h0);
    push(1, 0, 4'h0, 0, 4'h0);
    while (!done) begin
      n = (script.size() > 0) ? script.pop_front() : 4'hF;
      push(1, 0, 4'h0, 1, n);
      if (n == 4'h0) begin
        done = 1;
      end else if (n == 4'hA) begin
        exp_status = 2'b01;
        done = 1;
      end else if (n == 4'h5 || n == 4'h6) begin
        waits++;
        tmo = 0;
        if (waits > WaitMax) begin abort = 1; done = 1; end
      end else begin
        tmo++;
        if (tmo >= SyncTimeout) begin abort = 1; done = 1; end
      end
    end
    if (abort) begin
      for (int i = 0; i < 4; i++) push(0, 1, 4'hF, 0, 4'h0);
      exp_status = 2'b10;
    end else begin
      if (!wr) begin
        push(1, 0, 4'h0, 1, rdata[3:0]);
        push(1, 0, 4'h0, 1, rdata[7:4]);
        mdl_rdata = rdata;
      end
      push(1, 0, 4'h0, 1, 4'hF);
      push(1, 0, 4'h0, 1, 4'hF);
    end
    push(1, 0, 4'h0, 0, 4'h0);
  endtask

  // Present a request at a negedge; returns just after the accepting edge.
  task automatic issue(input string name, input logic wr, input logic [15:0] addr,
                       input logic [7:0] wdata);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    total++;
    if (req_ready_o !== 1'b1) begin
      bad++; $display("FAIL %s ready_before_accept got=%b want=1", name, req_ready_o);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Walk the expected frame from just after the accepting edge through RESP.
  task automatic run_trace(input string name);
    int last = exp_lframe.size() - 1;
    for (int i = 0; i <= last; i++) begin
      tgt_en = drv_en[i]; tgt_val = drv_val[i];
      @(negedge clk);
      total++;
      if (lframe_o !== exp_lframe[i]) begin
        bad++; $display("FAIL %s lframe cyc=%0d got=%b want=%b", name, i, lframe_o, exp_lframe[i]);
      end
      total++;
      if (dut.lad_oe !== exp_oe[i]) begin
        bad++; $display("FAIL %s lad_oe cyc=%0d got=%b want=%b", name, i, dut.lad_oe, exp_oe[i]);
      end
      if (exp_oe[i]) begin
        total++;
        if (lad_bus !== exp_lad[i]) begin
          bad++; $display("FAIL %s lad cyc=%0d got=%h want=%h", name, i, lad_bus, exp_lad[i]);
        end
      end
      total++;
      if (resp_valid_o !== (i == last)) begin
        bad++; $display("FAIL %s resp_valid cyc=%0d got=%b want=%b", name, i, resp_valid_o,
                        (i == last));
      end
      total++;
      if (busy_o !== 1'b1 || req_ready_o !== 1'b0) begin
        bad++; $display("FAIL %s busy/ready cyc=%0d got=%b/%b want=1/0", name, i, busy_o,
                        req_ready_o);
      end
      if (i == last) begin
        total++;
        if (resp_status_o !== exp_status) begin
          bad++; $display("FAIL %s status got=%b want=%b", name, resp_status_o, exp_status);
        end
        total++;
        if (resp_rdata_o !== mdl_rdata) begin
          bad++; $display("FAIL %s rdata got=%h want=%h", name, resp_rdata_o, mdl_rdata);
        end
      end
      @(posedge clk); #1;
    end
    tgt_en = 1'b0;
  endtask

  task automatic check_idle(input string name);
    total++;
    if (lframe_o !== 1'b1 || dut.lad_oe !== 1'b0 || req_ready_o !== 1'b1 ||
        resp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL %s idle lframe/oe/ready/resp/busy got=%b%b%b%b%b want=10110", name,
               lframe_o, dut.lad_oe, req_ready_o, resp_valid_o, busy_o);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_idle("reset");
    total++;
    if (resp_rdata_o !== 8'h00 || resp_status_o !== 2'b00) begin
      bad++; $display("FAIL reset resp got=%h/%b want=00/00", resp_rdata_o, resp_status_o);
    end
    nrst = 1'b1;
    mdl_rdata = 8'h00;
    @(negedge clk);
    check_idle("post_reset");
  endtask

  task automatic test_directed();
    script = '{4'h0};
    build_frame(1, 16'h0080, 8'hA5, 8'h00);
    issue("wr_zero_wait", 1, 16'h0080, 8'hA5);
    run_trace("wr_zero_wait");
    script = '{4'h5, 4'h5, 4'h0};
    build_frame(0, 16'h002E, 8'h00, 8'h5A);
    issue("rd_waits", 0, 16'h002E, 8'h00);
    run_trace("rd_waits");
    script.delete();
    build_frame(0, 16'h0060, 8'h00, 8'h00);
    issue("rd_no_target", 0, 16'h0060, 8'h00);
    run_trace("rd_no_target");
    script = '{4'hA};
    build_frame(1, 16'h03F8, 8'h3C, 8'h00);
    issue("wr_err_sync", 1, 16'h03F8, 8'h3C);
    run_trace("wr_err_sync");
    script = '{4'hA};
    build_frame(0, 16'h1234, 8'h00, 8'hC3);
    issue("rd_err_sync", 0, 16'h1234, 8'h00);
    run_trace("rd_err_sync");
  endtask

  task automatic test_limits();
    script.delete();
    for (int i = 0; i < WaitMax; i++) script.push_back(($urandom_range(0, 1) != 0) ? 4'h5 : 4'h6);
    script.push_back(4'h0);
    build_frame(0, 16'h0400, 8'h00, 8'h96);
    issue("wait_at_max", 0, 16'h0400, 8'h00);
    run_trace("wait_at_max");
    script.delete();
    for (int i = 0; i <= WaitMax; i++) script.push_back(4'h6);
    build_frame(1, 16'h0401, 8'h11, 8'h00);
    issue("wait_over_max", 1, 16'h0401, 8'h11);
    run_trace("wait_over_max");
    script.delete();
    for (int i = 0; i < SyncTimeout - 1; i++) script.push_back(junk_tab[$urandom_range(0, 11)]);
    script.push_back(4'h5);
    for (int i = 0; i < SyncTimeout - 1; i++) script.push_back(junk_tab[$urandom_range(0, 11)]);
    script.push_back(4'h0);
    build_frame(0, 16'h0402, 8'h00, 8'h7E);
    issue("timeout_cleared", 0, 16'h0402, 8'h00);
    run_trace("timeout_cleared");
    script.delete();
    for (int i = 0; i < SyncTimeout; i++) script.push_back(junk_tab[$urandom_range(0, 11)]);
    build_frame(0, 16'h0403, 8'h00, 8'h00);
    issue("timeout_hit", 0, 16'h0403, 8'h00);
    run_trace("timeout_hit");
  endtask

  task automatic test_random();
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wd, rd;
    int          sel;
    for (int k = 0; k < 24; k++) begin
      wr = 1'($urandom_range(0, 1)); addr = 16'($urandom); wd = 8'($urandom); rd = 8'($urandom);
      script.delete();
      for (int j = 0; j < int'($urandom_range(0, 5)); j++) begin
        sel = $urandom_range(0, 2);
        script.push_back(sel == 0 ? 4'h5 : sel == 1 ? 4'h6 : junk_tab[$urandom_range(0, 11)]);
      end
      sel = $urandom_range(0, 4);
      if (sel <= 2) script.push_back(4'h0);
      else if (sel == 3) script.push_back(4'hA);
      build_frame(wr, addr, wd, rd);
      issue("random", wr, addr, wd);
      run_trace("random");
    end
  endtask

  task automatic test_back_to_back();
    script = '{4'h0};
    build_frame(1, 16'h0080, 8'h42, 8'h00);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0080; req_wdata = 8'h42;
    @(posedge clk); #1;
    // Second request held valid for the whole first frame.
    req_write = 1'b0; req_addr = 16'h0081;
    run_trace("b2b_first");
    @(negedge clk);
    total++;
    if (req_ready_o !== 1'b1 || lframe_o !== 1'b1 || resp_valid_o !== 1'b0) begin
      bad++; $display("FAIL b2b gap ready/lframe/resp got=%b%b%b want=110", req_ready_o,
                      lframe_o, resp_valid_o);
    end
    script = '{4'h6, 4'h0};
    build_frame(0, 16'h0081, 8'h00, 8'hE1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    run_trace("b2b_second");
  endtask

  task automatic test_reset_mid();
    script = '{4'h0};
    build_frame(1, 16'hBEEF, 8'h77, 8'h00);
    issue("rst_mid", 1, 16'hBEEF, 8'h77);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (lad_bus !== 4'hE) begin
      bad++; $display("FAIL rst_mid addr_nibble2 got=%h want=e", lad_bus);
    end
    #2 nrst = 1'b0;
    #1;
    check_idle("rst_async");
    mdl_rdata = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("rst_held");
    end
    nrst = 1'b1;
    total++;
    if (resp_rdata_o !== 8'h00 || resp_status_o !== 2'b00) begin
      bad++; $display("FAIL rst_mid resp got=%h/%b want=00/00", resp_rdata_o, resp_status_o);
    end
    script = '{4'h0};
    build_frame(0, 16'h0070, 8'h00, 8'hB4);
    issue("after_rst", 0, 16'h0070, 8'h00);
    run_trace("after_rst");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_limits();
    test_random();
    test_back_to_back();
    test_reset_mid();
    @(negedge clk);
    check_idle("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
